// File: rtl/freelist_alloc_pkg.sv
// Shared sizes, tag/pointer types and a popcount helper for the R10K free list.
// FL_PTR carries one extra wrap bit above the array index.
package freelist_alloc_pkg;

  localparam int N                = 3;
  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int ARCH_REG_SZ      = 32;
  localparam int FL_DEPTH         = PHYS_REG_SZ_R10K - ARCH_REG_SZ;
  localparam int PHYS_TAG_BITS    = $clog2(PHYS_REG_SZ_R10K);
  localparam int FL_IDX_BITS      = $clog2(FL_DEPTH);
  localparam int CNT_BITS         = $clog2(PHYS_REG_SZ_R10K + 1);
  localparam int RET_BITS         = $clog2(N + 1);

  typedef logic [PHYS_TAG_BITS-1:0]    PHYS_TAG;
  typedef logic [FL_IDX_BITS:0]        FL_PTR;
  typedef logic [PHYS_REG_SZ_R10K-1:0] ONEHOT_T;

  function automatic logic [RET_BITS-1:0] popcountN(input logic [N-1:0] v);
    popcountN = '0;
    for (int i = 0; i < N; i++) begin
      popcountN = popcountN + RET_BITS'(v[i]);
    end
  endfunction

endpackage

// File: rtl/freelist_alloc_if.sv
// Dispatch/retire/recovery bundle of the free list; master drives requests,
// slave is the allocator.
interface freelist_alloc_if;
  import freelist_alloc_pkg::*;

  logic [N-1:0]             alloc_req;
  ONEHOT_T [N-1:0]          granted_regs;
  logic [CNT_BITS-1:0]      free_slots_freelst;
  logic [N-1:0]             free_valid;
  PHYS_TAG [N-1:0]          free_tags;
  logic [RET_BITS-1:0]      retire_alloc_count;
  logic                     recover;

  modport master (
    output alloc_req, free_valid, free_tags, retire_alloc_count, recover,
    input  granted_regs, free_slots_freelst
  );

  modport slave (
    input  alloc_req, free_valid, free_tags, retire_alloc_count, recover,
    output granted_regs, free_slots_freelst
  );

endinterface

// File: rtl/freelist_alloc_onehot_encode_n.sv
// Turns N binary physical tags into N one-hot vectors; an invalid slot
// produces an all-zero vector.
module onehot_encode_n
  import freelist_alloc_pkg::*;
(
  input  logic [N-1:0]    valid_i,
  input  PHYS_TAG [N-1:0] tags_i,
  output ONEHOT_T [N-1:0] onehot_o
);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = valid_i[i] ? (ONEHOT_T'(1) << tags_i[i]) : '0;
    end
  end

endmodule

// File: rtl/freelist_alloc.sv
// R10K physical-register free list: circular tag array with allocate (head),
// free (tail) and committed (chead) pointers, rolled back to chead on recovery.
module freelist_alloc
  import freelist_alloc_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  freelist_alloc_if.slave bus
);

  if ((FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_depth_check
    $error("freelist_alloc: FL_DEPTH must be a power of two");
  end

  PHYS_TAG                fl_q [FL_DEPTH];
  FL_PTR                  head_q, head_d;
  FL_PTR                  tail_q, tail_d;
  FL_PTR                  chead_q, chead_d;
  FL_PTR                  count_q, count_d;

  logic [RET_BITS-1:0]    rank [N];
  logic [FL_IDX_BITS-1:0] readIdx [N];
  logic [N-1:0]           grantValid;
  PHYS_TAG [N-1:0]        grantTag;
  FL_PTR                  reqCount;
  FL_PTR                  numGrant;

  logic [N-1:0]           writeEn;
  logic [FL_IDX_BITS-1:0] writeIdx [N];
  FL_PTR                  accepted;

  // Requests are compacted: a slot's rank is how many lower slots also request.
  always_comb begin
    grantValid = '0;
    grantTag   = '0;
    reqCount   = FL_PTR'(popcountN(bus.alloc_req));
    for (int i = 0; i < N; i++) begin
      rank[i]       = popcountN(bus.alloc_req & N'((1 << i) - 1));
      readIdx[i]    = head_q[FL_IDX_BITS-1:0] + FL_IDX_BITS'(rank[i]);
      grantTag[i]   = fl_q[readIdx[i]];
      grantValid[i] = reset && !bus.recover && bus.alloc_req[i]
                      && (FL_PTR'(rank[i]) < count_q);
    end
    if (bus.recover) begin
      numGrant = '0;
    end else begin
      numGrant = (reqCount < count_q) ? reqCount : count_q;
    end
  end

  // Frees beyond the remaining capacity are dropped so the count saturates.
  always_comb begin
    accepted = '0;
    writeEn  = '0;
    for (int j = 0; j < N; j++) begin
      writeIdx[j] = tail_q[FL_IDX_BITS-1:0] + accepted[FL_IDX_BITS-1:0];
      if (bus.free_valid[j] && ((count_q + accepted) < FL_PTR'(FL_DEPTH))) begin
        writeEn[j] = 1'b1;
        accepted   = accepted + FL_PTR'(1);
      end
    end
  end

  always_comb begin
    chead_d = chead_q + FL_PTR'(bus.retire_alloc_count);
    head_d  = bus.recover ? chead_d : (head_q + numGrant);
    tail_d  = tail_q + accepted;
    count_d = tail_d - head_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        fl_q[k] <= PHYS_TAG'(ARCH_REG_SZ + k);
      end
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= FL_PTR'(FL_DEPTH);
      count_q <= FL_PTR'(FL_DEPTH);
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int j = 0; j < N; j++) begin
        if (writeEn[j]) begin
          fl_q[writeIdx[j]] <= bus.free_tags[j];
        end
      end
    end
  end

  onehot_encode_n u_encode (
    .valid_i  (grantValid),
    .tags_i   (grantTag),
    .onehot_o (bus.granted_regs)
  );

  assign bus.free_slots_freelst = CNT_BITS'(count_q);

  // Returning more tags than the list can hold means retire logic is broken.
  assert property (@(posedge clock) disable iff (!reset)
    (count_q + FL_PTR'(popcountN(bus.free_valid))) <= FL_PTR'(FL_DEPTH));

  for (genvar g = 0; g < N; g++) begin : g_tag0_check
    assert property (@(posedge clock) disable iff (!reset)
      !(bus.free_valid[g] && (bus.free_tags[g] == '0)));
  end

endmodule

// File: doc/freelist_alloc.md
Name: freelist_alloc

Overview:
- R10K physical-register free list and allocator that shares free tags among up to N dispatch slots per cycle.
- Returns tags to the list from retirement and rolls allocation back to the committed state on recovery.
- Feeds dispatch its `granted_regs` one-hot grants and its `free_slots_freelst` count.
- Sits between dispatch (allocation), ROB retire (free / commit) and the recovery logic.

Parameters:
- N, 3, dispatch/retire width.
- PHYS_REG_SZ_R10K, 64, number of physical registers.
- ARCH_REG_SZ, 32, architectural registers; physical 0..ARCH_REG_SZ-1 are mapped at reset.
- FL_DEPTH, PHYS_REG_SZ_R10K-ARCH_REG_SZ, free-list capacity (32).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- alloc_req  in  N  slot i wants a destination tag (dispatch `free_alloc_valid`).
- granted_regs  out  N x PHYS_REG_SZ_R10K  one-hot grant per slot; all-zero means no grant.
- free_slots_freelst  out  $clog2(PHYS_REG_SZ_R10K+1)  current free count (registered).
- free_valid  in  N  retire slot i returns a tag.
- free_tags  in  N x PHYS_TAG  tags returned (retiring T_old).
- retire_alloc_count  in  $clog2(N+1)  retiring instructions this cycle that own a destination tag.
- recover  in  1  squash: discard every uncommitted allocation.

Behaviour:
- Storage: circular array `fl[FL_DEPTH]` of PHYS_TAG. Three pointers, each with an extra wrap bit:
  - `head`: next tag to allocate.
  - `tail`: next write position.
  - `chead`: committed head.
- Count: `count = tail - head` (wrap-bit arithmetic), registered. `free_slots_freelst = count`, zero-extended.
- Reset (reset=0, asynchronous):
  - `fl[k] = ARCH_REG_SZ + k`.
  - `head = chead = 0`; `tail = FL_DEPTH` (wrap bit 1, index 0).
  - `count = FL_DEPTH` (32).
  - `granted_regs` forced to 0 while reset is low.
- Grant (combinational, same cycle as `alloc_req`):
  - Slot i has rank r = popcount(`alloc_req[i-1:0]`).
  - If `alloc_req[i]` and r < count: `granted_regs[i] = onehot(fl[head+r])`; otherwise all-zero.
  - Requests are compacted in slot order; a gap in `alloc_req` consumes no entry.
- Allocate (clock edge): `head += min(popcount(alloc_req), count)`. Over-request is legal; the unserved high-rank slots simply get no grant.
- Free (clock edge): valid `free_tags` are written in slot order at `tail, tail+1, ...`; `tail += popcount(free_valid)`.
  - Tags freed in cycle t are first grantable in cycle t+1. No same-cycle bypass.
- Commit (clock edge): `chead += retire_alloc_count`. Retire logic guarantees `chead` never passes `head`.
- Recover:
  - `alloc_req` is ignored in that cycle: all grants are zero and `head` is not advanced from requests.
  - Next state: `head = chead + retire_alloc_count`, so same-cycle commits are honoured.
  - Frees in the same cycle are still applied to `tail`.
  - Next-cycle count = new tail − new head.
- Simultaneous alloc + free + commit in one cycle: all three pointers update independently. The count update is `count + frees − grants` (or the recovery formula above).
- Overflow: a free when `count + frees > FL_DEPTH` is an illegal-stimulus error.
  - Simulation assertion fires; excess tags are dropped, so the count saturates at FL_DEPTH.
- Tag 0 is never freed; an assertion fires if `free_tags` = 0 with `free_valid` set.
- Wrap-around: indices are taken modulo FL_DEPTH via the low $clog2(FL_DEPTH) bits, and the wrap bit distinguishes full from empty.
  - FL_DEPTH must be a power of two; enforce with an elaboration check.
- Latency: grant is 0 cycles; the count reflects an allocation 1 cycle later.

Decomposition:
- Shared package (sys_defs): PHYS_TAG, PHYS_TAG_BITS, `PHYS_REG_SZ_R10K`, ARCH_REG_SZ, `N`, FL_PTR (index + wrap bit).
- One natural sub-module: `onehot_encode_n`, turning N binary tags into N one-hot vectors.
- Pointer and rank logic stay in the top module.

Test Plan:
- Reset release, no requests:
  - `free_slots_freelst` = 32.
  - `alloc_req=3'b111` gives grants onehot(32), onehot(33), onehot(34); next cycle count = 29.
- Gap compaction: `alloc_req=3'b101` after reset gives slot0 onehot(32), slot1 0, slot2 onehot(33); count → 30.
- Exhaustion:
  - Allocate until count = 1, then `alloc_req=3'b111`: only slot0 is granted and count → 0.
  - Next cycle `alloc_req=3'b001`: zero grant, count stays 0.
- Free/alloc same cycle:
  - At count = 0, free tags 5 and 7 with `alloc_req=3'b001`: no grant that cycle, count → 2.
  - Next cycle `alloc_req=3'b011` grants onehot(5), onehot(7), in order across the wrap point.
- Recovery:
  - After reset, allocate 6 tags over 2 cycles and commit 2.
  - Then assert `recover` with `retire_alloc_count=1`: grants are zero that cycle, `head` = 3, count → 29.
  - Next `alloc_req=3'b001` grants onehot(35).
- Async reset mid-operation: drop reset low mid-cycle with count = 10. Count reads 32 and grants read 0 immediately, with no clock edge.
